// File: rtl/memory_responder_if.sv
// memory_responder_if: cache-side line request, write-back and fill channels
interface memory_responder_if #(
  parameter int ADDRESS_WORD_SIZE = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDRESS_WORD_SIZE-1:0] req_addr;
  logic                         wb_valid;
  logic [7:0]                   wb_data;
  logic                         wb_ready;
  logic                         rsp_valid;
  logic [7:0]                   rsp_data;
  logic                         rsp_last;
  logic                         rsp_ready;
  logic                         done;
  modport master (
    output req_valid, req_write, req_addr, wb_valid, wb_data, rsp_ready,
    input  req_ready, wb_ready, rsp_valid, rsp_data, rsp_last, done
  );
  modport slave (
    input  req_valid, req_write, req_addr, wb_valid, wb_data, rsp_ready,
    output req_ready, wb_ready, rsp_valid, rsp_data, rsp_last, done
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: line-granular backing store answering cache fills and write-backs
module memory_responder #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int BLOCK_SIZE        = 16,
  parameter int NUMBER_OF_LINES   = 64,
  parameter int MEM_LATENCY       = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  memory_responder_if.slave  bus
);
  localparam int OW = $clog2(BLOCK_SIZE);
  localparam int IW = $clog2(NUMBER_OF_LINES);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [OW-1:0] LAST_CNT = OW'(BLOCK_SIZE - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(MEM_LATENCY - 1);
  typedef enum logic [2:0] {IDLE, FILL_WAIT, FILL_BURST, WB_RECV, WB_COMMIT} state_t;
  state_t                       r_state, w_state_nxt;
  logic [OW-1:0]                r_cnt, w_cnt_nxt;
  logic [LW-1:0]                r_lat, w_lat_nxt;
  logic [IW-1:0]                r_idx;
  logic                         r_done, w_done_nxt, w_we;
  logic [ADDRESS_WORD_SIZE-1:0] w_addr;
  logic                         w_unused;
  logic [7:0]                   r_mem [NUMBER_OF_LINES*BLOCK_SIZE];
  assign w_addr   = bus.req_addr;
  assign w_unused = ^w_addr;
  // state, counters, latched line index and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && bus.req_valid) r_idx <= w_addr[OW+IW-1:OW];
    end
  end
  // storage survives reset; a reset edge never commits a byte
  always_ff @(posedge clk) begin
    if (rst_b && w_we) r_mem[{r_idx, r_cnt}] <= bus.wb_data;
  end
  // next-state, counter updates and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lat_nxt     = r_lat;
    w_done_nxt    = 1'b0;
    w_we          = 1'b0;
    bus.req_ready = r_state == IDLE;
    bus.wb_ready  = r_state == WB_RECV;
    bus.rsp_valid = r_state == FILL_BURST;
    bus.rsp_last  = bus.rsp_valid && r_cnt == LAST_CNT;
    bus.rsp_data  = bus.rsp_valid ? r_mem[{r_idx, r_cnt}] : 8'h00;
    bus.done      = r_done;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        w_state_nxt = bus.req_write ? WB_RECV : FILL_WAIT;
        w_cnt_nxt   = '0;
        w_lat_nxt   = '0;
      end
      FILL_WAIT: begin
        w_lat_nxt = r_lat + 1'b1;
        if (r_lat == LAST_LAT) w_state_nxt = FILL_BURST;
      end
      FILL_BURST: if (bus.rsp_ready) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      WB_RECV: if (bus.wb_valid) begin
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = WB_COMMIT;
          w_lat_nxt   = '0;
        end
      end
      WB_COMMIT: begin
        w_lat_nxt = r_lat + 1'b1;
        if (r_lat == LAST_LAT) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed line-operation vectors plus reset/back-to-back corner sequences
module tb_memory_responder;
  localparam int LAT = 4;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  base;
    logic        tog;
    logic [7:0]  exp_base;
  } vec_t;
  logic clk, rst_b;
  int   checks, errors;
  vec_t vecs [9];
  memory_responder_if #(.ADDRESS_WORD_SIZE(32)) bus ();
  memory_responder #(
    .ADDRESS_WORD_SIZE(32), .BLOCK_SIZE(16), .NUMBER_OF_LINES(64), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] mk(input logic [7:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_wb(input logic [31:0] addr, input logic [7:0] base);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    chk("wb_req_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wb_data = base + 8'(i);
      chk("wb_ready_on", bus.wb_ready, 1);
      chk("wb_busy_req_ready", bus.req_ready, 0);
      chk("wb_busy_done", bus.done, 0);
      step();
    end
    bus.wb_valid = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      chk("wb_commit_ready", bus.wb_ready, 0);
      chk("wb_commit_done", bus.done, 0);
      chk("wb_commit_req_ready", bus.req_ready, 0);
      step();
    end
    chk("wb_done", bus.done, 1);
    chk("wb_idle_req_ready", bus.req_ready, 1);
    chk("wb_idle_wb_ready", bus.wb_ready, 0);
  endtask
  task automatic do_fill(input logic [31:0] addr, input logic [127:0] exp, input bit tog, input bit hold);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.rsp_ready = 1'b1;
    chk("fill_req_ready", bus.req_ready, 1);
    step();
    if (!hold) bus.req_valid = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      chk("fill_wait_valid", bus.rsp_valid, 0);
      chk("fill_wait_last", bus.rsp_last, 0);
      chk("fill_wait_req_ready", bus.req_ready, 0);
      chk("fill_wait_done", bus.done, 0);
      step();
    end
    for (int c = 0; c < 100 && n < 16; c++) begin
      bus.rsp_ready = tog ? c[0] : 1'b1;
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_data", bus.rsp_data, exp[n*8 +: 8]);
      chk("rsp_last", bus.rsp_last, n == 15);
      chk("fill_busy_req_ready", bus.req_ready, 0);
      if (bus.rsp_ready) n++;
      step();
    end
    bus.rsp_ready = 1'b1;
    chk("fill_byte_count", n, 16);
    chk("fill_done", bus.done, 1);
    chk("fill_idle_valid", bus.rsp_valid, 0);
    chk("fill_idle_req_ready", bus.req_ready, 1);
  endtask
  initial begin
    logic [127:0] e;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_b = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_data   = '0;
    bus.rsp_ready = 1'b0;
    vecs[0] = '{1'b1, 32'h040, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 32'h04C, 8'h00, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 32'h04C, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 32'h080, 8'hA0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 32'h440, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 32'h08F, 8'h00, 1'b0, 8'hA0};
    vecs[6] = '{1'b1, 32'h840, 8'h30, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 32'h040, 8'h00, 1'b0, 8'h30};
    vecs[8] = '{1'b0, 32'h080, 8'h00, 1'b1, 8'hA0};
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_wb_ready", bus.wb_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_last", bus.rsp_last, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_done", bus.done, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) do_wb(vecs[i].addr, vecs[i].base);
      else do_fill(vecs[i].addr, mk(vecs[i].exp_base), vecs[i].tog, 1'b0);
    end
    do_fill(32'h080, mk(8'hA0), 1'b0, 1'b1);
    do_fill(32'h080, mk(8'hA0), 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h040;
    step();
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wb_data = 8'hE0 + 8'(i);
      chk("abort_wb_ready", bus.wb_ready, 1);
      step();
    end
    bus.wb_valid = 1'b0;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_wb_ready_off", bus.wb_ready, 0);
    chk("abort_no_done", bus.done, 0);
    step();
    chk("abort_no_done_late", bus.done, 0);
    e = mk(8'h30);
    e[39:0] = 40'hE4E3E2E1E0;
    do_fill(32'h040, e, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WORD_SIZE, default 32, request address width.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16, bytes per cache line (power of 2, >=2).
REQ-003 SHALL have parameter NUMBER_OF_LINES, default 64, lines of backing store (power of 2).
REQ-004 SHALL have parameter MEM_LATENCY, default 4, access latency in cycles (>=1).
REQ-005 SHALL have one clock and synchronous, active-low reset: clk input 1, rising-edge clock; rst_b input 1, synchronous active-low reset.
REQ-006 SHALL have req_valid  input  1  cache requests a line operation.
REQ-007 SHALL have req_ready  output  1  responder can accept a request.
REQ-008 SHALL have req_write  input  1  1 = write-back line, 0 = line fill.
REQ-009 SHALL have req_addr  input  ADDRESS_WORD_SIZE  byte address of line.
REQ-010 SHALL have wb_valid  input  1  write-back byte valid.
REQ-011 SHALL have wb_data  input  8  write-back byte.
REQ-012 SHALL have wb_ready  output  1  responder accepts write-back byte.
REQ-013 SHALL have rsp_valid  output  1  fill byte valid.
REQ-014 SHALL have rsp_data  output  8  fill byte.
REQ-015 SHALL have rsp_last  output  1  marks byte BLOCK_SIZE-1 of a fill.
REQ-016 SHALL have rsp_ready  input  1  cache accepts fill byte.
REQ-017 SHALL have done  output  1  one-cycle pulse on operation completion.

Function
REQ-018 SHALL use FSM states IDLE, FILL_WAIT, FILL_BURST, WB_RECV, WB_COMMIT.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on the rising edge where req_valid && req_ready.
REQ-020 SHALL latch line index = req_addr[log2(BLOCK_SIZE)+log2(NUMBER_OF_LINES)-1 : log2(BLOCK_SIZE)] and req_write at acceptance; offset bits ignored, upper bits ignored (index wraps).
REQ-021 SHALL, on a fill accepted at edge k, stay in FILL_WAIT and assert rsp_valid first in the cycle starting at edge k+MEM_LATENCY.
REQ-022 SHALL in FILL_BURST present rsp_data = byte at offset cnt of the latched line, cnt starting at 0, holding rsp_valid/rsp_data stable until rsp_valid && rsp_ready.
REQ-023 SHALL increment cnt on each rsp handshake; rsp_last=1 exactly when cnt==BLOCK_SIZE-1 and rsp_valid=1.
REQ-024 SHALL, on the rsp handshake with rsp_last=1, return to IDLE and pulse done for the following cycle.
REQ-025 SHALL, on a write-back accepted, enter WB_RECV with wb_ready=1 in the next cycle; each edge with wb_valid && wb_ready writes wb_data to offset cnt of the latched line and increments cnt.
REQ-026 SHALL, after byte BLOCK_SIZE-1 is accepted, deassert wb_ready, enter WB_COMMIT for MEM_LATENCY cycles, then return to IDLE and pulse done for one cycle.
REQ-027 SHALL ignore wb_valid outside WB_RECV and rsp_ready outside FILL_BURST.
REQ-028 SHALL keep wb_ready=0, rsp_valid=0, rsp_last=0 whenever not in WB_RECV/FILL_BURST respectively.
REQ-029 SHALL allow a new request to be accepted in the same cycle done is high (req_ready=1 in IDLE).
REQ-030 SHALL make a fill following a write-back to the same line return the written bytes (no stale data).
REQ-031 SHALL use a counter width of log2(BLOCK_SIZE) for cnt and a latency counter wide enough for MEM_LATENCY; cnt resets to 0 at each request acceptance.

Reset
REQ-032 SHALL, when rst_b=0 at a rising edge, go to IDLE and set req_ready=1 (after reset), wb_ready=0, rsp_valid=0, rsp_last=0, rsp_data=8'h00, done=0, cnt=0.
REQ-033 SHALL, on reset mid-operation, abort without done; write-back bytes already stored remain in memory; storage contents are not cleared by reset.

Verification
REQ-034 SHALL cover: write-back addr 0x40 bytes 0x00..0x0F, wb_valid continuous -> wb_ready 16 cycles, done pulse MEM_LATENCY cycles after last byte.
REQ-035 SHALL cover: fill addr 0x4C after REQ-034 -> rsp_valid first at k+4, bytes 0x00..0x0F in order, rsp_last only on 0x0F, done next cycle.
REQ-036 SHALL cover: fill with rsp_ready toggling 1/0 -> rsp_data held while rsp_ready=0, no byte dropped or duplicated.
REQ-037 SHALL cover: req_valid held high during busy operation -> req_ready=0, second request accepted only in IDLE/done cycle.
REQ-038 SHALL cover: rst_b=0 after 5 write-back bytes -> IDLE next cycle, no done; later fill returns those 5 new bytes at offsets 0..4.
REQ-039 SHALL cover: addr 0x440 (index wrap, NUMBER_OF_LINES=64) -> aliases line 0x40/16=4 data.
